// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared types and defaults for the IR sensor scheduler
// Contents: arbiter state enum, default parameter values, channel-index width helper.
package ir_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    localparam int N_CH_DEF    = 4;
    localparam int DIV_W_DEF   = 10;
    localparam int DEB_LEN_DEF = 6;
    localparam int CNT_W_DEF   = 8;

    // Width of a channel index; never below one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ir_sensor_scheduler_if.sv
// rtl/ir_sensor_scheduler_if.sv - valid/ready event port of the IR scheduler
// Signals: evt_valid (event offered), evt_ch (channel of offered event), evt_ready (consumer accepts).
// Modports: master = scheduler side, slave = consumer side.
interface ir_sensor_scheduler_if
    import ir_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
);
    localparam int CH_W = ch_width(N_CH);

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;

    modport master (
        output evt_valid,
        output evt_ch,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        output evt_ready
    );
endinterface

// File: rtl/ir_channel_filter.sv
// rtl/ir_channel_filter.sv - one IR channel: synchronizer, tick-gated debounce, hysteresis level, rise pulse
// Ports: clk, rst (async active-low), tick (sample strobe), ir_n (raw active-low sensor),
//        level (debounced detection, 1 = object), rise (one-cycle pulse on level rising).
module ir_channel_filter
    import ir_pkg::*;
#(
    parameter int DEB_LEN = DEB_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic ir_n,
    output logic level,
    output logic rise
);

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [DEB_LEN-1:0] sh_q, sh_d;
    logic               level_q, level_d;
    logic               level_prev_q, level_prev_d;

    always_comb begin
        // Invert at the pin so everything downstream is active-high.
        sync1_d      = ~ir_n;
        sync2_d      = sync1_q;
        sh_d         = sh_q;
        if (tick) begin
            sh_d = {sh_q[DEB_LEN-2:0], sync2_q};
        end
        // Hysteresis: only a full window of equal samples moves the level.
        level_d      = level_q;
        if (&sh_q) begin
            level_d = 1'b1;
        end else if (~|sh_q) begin
            level_d = 1'b0;
        end
        level_prev_d = level_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sh_q         <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sh_q         <= sh_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_prev_q;

endmodule

// File: rtl/ir_sensor_scheduler.sv
// rtl/ir_sensor_scheduler.sv - multi-channel IR front end with round-robin event arbiter
// Ports: clk, rst (async active-low), ir_n[N_CH] (raw sensors, low = object),
//        clr_drop (clear sticky drop bits), evt_if (master: evt_valid/evt_ch out, evt_ready in),
//        ch_level[N_CH] (debounced levels), drop[N_CH] (sticky lost-event flags),
//        evt_total[CNT_W] (saturating accepted-event count, only when IR_SCHED_EVT_COUNT_EN is defined).
// Optional feature macro: IR_SCHED_EVT_COUNT_EN.
module ir_sensor_scheduler
    import ir_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEB_LEN = DEB_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      ir_n,
    input  logic                 clr_drop,
    ir_sensor_scheduler_if.master evt_if,
    output logic [N_CH-1:0]      ch_level,
    output logic [N_CH-1:0]      drop
`ifdef IR_SCHED_EVT_COUNT_EN
    ,
    output logic [CNT_W-1:0]     evt_total
`endif
);

    localparam int CH_W = ch_width(N_CH);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  drop_q, drop_d;
    arb_state_t       state_q, state_d;
    logic             evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             accept;
    logic             grant_found;
    logic [CH_W-1:0]  grant_ch;
    logic [CH_W-1:0]  cand;

    // Sample strobe: one cycle out of every 2^DIV_W.
    assign div_d = div_q + 1'b1;
    assign tick  = &div_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ir_channel_filter #(
            .DEB_LEN (DEB_LEN)
        ) u_filter (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .ir_n  (ir_n[g]),
            .level (ch_level[g]),
            .rise  (rise[g])
        );
    end

    assign accept = evt_valid_q & evt_if.evt_ready;

    // Round-robin search: first pending channel at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = CH_W'((int'(rr_ptr_q) + k) % N_CH);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    // A new rise beats a same-cycle accept (event stays pending, no drop),
    // and a drop-setting rise beats a same-cycle clr_drop.
    always_comb begin
        pending_d = pending_q;
        drop_d    = drop_q;
        for (int i = 0; i < N_CH; i++) begin
            logic clr_sel;
            clr_sel      = accept && (evt_ch_q == CH_W'(i));
            pending_d[i] = rise[i] | (pending_q[i] & ~clr_sel);
            drop_d[i]    = (rise[i] & pending_q[i] & ~clr_sel) | (drop_q[i] & ~clr_drop);
        end
    end

    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d     = ST_OFFER;
                    evt_valid_d = 1'b1;
                    evt_ch_d    = grant_ch;
                end
            end
            ST_OFFER: begin
                if (evt_if.evt_ready) begin
                    state_d     = ST_IDLE;
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = (evt_ch_q == CH_W'(N_CH - 1)) ? '0 : evt_ch_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

`ifdef IR_SCHED_EVT_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d     = (accept && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    assign evt_total = cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q       <= '0;
            pending_q   <= '0;
            drop_q      <= '0;
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            rr_ptr_q    <= '0;
`ifdef IR_SCHED_EVT_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            div_q       <= div_d;
            pending_q   <= pending_d;
            drop_q      <= drop_d;
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef IR_SCHED_EVT_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign evt_if.evt_valid = evt_valid_q;
    assign evt_if.evt_ch    = evt_ch_q;
    assign drop             = drop_q;

endmodule

// File: tb/tb_ir_sensor_scheduler.sv
// tb/tb_ir_sensor_scheduler.sv - self-checking bench for ir_sensor_scheduler with an event scoreboard
module tb_ir_sensor_scheduler;
    import ir_pkg::*;

    localparam int N_CH    = 4;
    localparam int DIV_W   = 2;
    localparam int DEB_LEN = 6;
    localparam int CNT_W   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N_CH-1:0] ir_n = '1;
    logic            clr_drop = 1'b0;
    logic [N_CH-1:0] ch_level;
    logic [N_CH-1:0] drop;
`ifdef IR_SCHED_EVT_COUNT_EN
    logic [CNT_W-1:0] evt_total;
`endif

    ir_sensor_scheduler_if #(.N_CH(N_CH)) evt_if ();

    ir_sensor_scheduler #(
        .N_CH    (N_CH),
        .DIV_W   (DIV_W),
        .DEB_LEN (DEB_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ir_n     (ir_n),
        .clr_drop (clr_drop),
        .evt_if   (evt_if),
        .ch_level (ch_level),
        .drop     (drop)
`ifdef IR_SCHED_EVT_COUNT_EN
        ,
        .evt_total (evt_total)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_acc = 0;
    int acc_cyc[$];
    int exp_q[$];
    int model_ptr = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference round-robin order for channels whose events arrive together.
    task automatic push_rr(input logic [N_CH-1:0] mask);
        logic [N_CH-1:0] m;
        m = mask;
        while (m != '0) begin
            for (int k = 0; k < N_CH; k++) begin
                int c;
                c = (model_ptr + k) % N_CH;
                if (m[c]) begin
                    m[c] = 1'b0;
                    exp_q.push_back(c);
                    model_ptr = (c + 1) % N_CH;
                    break;
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid(input int lim, output int took);
        took = -1;
        for (int i = 0; i < lim; i++) begin
            step(1);
            if (evt_if.evt_valid) begin
                took = i + 1;
                break;
            end
        end
    endtask

    // Monitor: every accepted event is popped against the scoreboard.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst && evt_if.evt_valid && evt_if.evt_ready) begin
            n_acc++;
            acc_cyc.push_back(cyc);
            chk("sb_has_exp", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("evt_ch", int'(evt_if.evt_ch), exp_q.pop_front());
        end
    end

    initial begin
        int lat;
        int took;
        int acc0;
        int seen;
        int stable;

        evt_if.evt_ready = 1'b0;
        step(3);
        chk("rst_valid", int'(evt_if.evt_valid), 0);
        chk("rst_ch", int'(evt_if.evt_ch), 0);
        chk("rst_level", int'(ch_level), 0);
        chk("rst_drop", int'(drop), 0);
        rst = 1'b1;
        step(2);

        // Single channel detection, consumer always ready.
        evt_if.evt_ready = 1'b1;
        ir_n[1] = 1'b0;
        push_rr(4'b0010);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            lat++;
            if (ch_level[1]) break;
        end
        chk("lvl_lat_ok", int'(lat >= 24 && lat <= 27), 1);
        wait_valid(10, took);
        chk("valid_lat", took, 2);
        step(1);
        chk("valid_one_cycle", int'(evt_if.evt_valid), 0);
        step(2);
        chk("pending_zero", int'(dut.pending_q), 0);
        chk("sb_drained1", exp_q.size(), 0);
        step(10);
        ir_n[1] = 1'b1;
        step(40);
        chk("lvl1_fall", int'(ch_level), 0);

        // Short glitch must not pass the debounce.
        acc0 = n_acc;
        seen = 0;
        ir_n[0] = 1'b0;
        step(12);
        ir_n[0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (ch_level[0]) seen = 1;
        end
        chk("glitch_lvl", seen, 0);
        chk("glitch_no_evt", n_acc, acc0);

        // Simultaneous edges from a known pointer position.
        rst = 1'b0;
        step(2);
        exp_q.delete();
        model_ptr = 0;
        rst = 1'b1;
        step(2);
        acc_cyc.delete();
        ir_n[0] = 1'b0;
        ir_n[2] = 1'b0;
        push_rr(4'b0101);
        step(50);
        chk("pair02_cnt", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) chk("pair02_gap", acc_cyc[1] - acc_cyc[0], 2);
        chk("sb_drained2", exp_q.size(), 0);
        ir_n = '1;
        step(40);
        acc_cyc.delete();
        ir_n[2] = 1'b0;
        ir_n[3] = 1'b0;
        push_rr(4'b1100);
        step(50);
        chk("pair23_cnt", acc_cyc.size(), 2);
        chk("sb_drained3", exp_q.size(), 0);
        ir_n = '1;
        step(40);

        // Stalled consumer: a second rise on the offered channel is merged and flagged.
        evt_if.evt_ready = 1'b0;
        ir_n[1] = 1'b0;
        push_rr(4'b0010);
        wait_valid(60, took);
        chk("hold_seen", int'(took > 0), 1);
        chk("hold_ch", int'(evt_if.evt_ch), 1);
        stable = 1;
        ir_n[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!evt_if.evt_valid || evt_if.evt_ch != 2'd1) stable = 0;
        end
        ir_n[1] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!evt_if.evt_valid || evt_if.evt_ch != 2'd1) stable = 0;
        end
        chk("hold_stable", stable, 1);
        chk("drop1", int'(drop), 2);
        clr_drop = 1'b1;
        step(1);
        clr_drop = 1'b0;
        chk("drop_clr", int'(drop), 0);
        acc0 = n_acc;
        evt_if.evt_ready = 1'b1;
        step(3);
        chk("merged_one", n_acc - acc0, 1);
        chk("merged_idle", int'(evt_if.evt_valid), 0);
        ir_n[1] = 1'b1;
        step(40);

        // Reset in the middle of an offer discards it.
        evt_if.evt_ready = 1'b0;
        ir_n[2] = 1'b0;
        wait_valid(60, took);
        chk("rst_offer_seen", int'(took > 0), 1);
        ir_n[2] = 1'b1;
        #1 rst = 1'b0;
        #1 chk("rst_async_valid", int'(evt_if.evt_valid), 0);
        exp_q.delete();
        model_ptr = 0;
        step(3);
        rst = 1'b1;
        evt_if.evt_ready = 1'b1;
        acc0 = n_acc;
        step(60);
        chk("rst_no_reoffer", n_acc, acc0);
        chk("rst_valid_low", int'(evt_if.evt_valid), 0);

`ifdef IR_SCHED_EVT_COUNT_EN
        chk("cnt_rst", int'(evt_total), 0);
        for (int e = 0; e < 5; e++) begin
            ir_n[0] = 1'b0;
            push_rr(4'b0001);
            step(35);
            ir_n[0] = 1'b1;
            step(35);
        end
        chk("cnt_sat", int'(evt_total), 3);
        chk("sb_drained4", exp_q.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
